serial_tx: RTL



---
 rtl/serial_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Parallel-to-serial line transmitter. Accepts a WIDTH-bit word
//             on a valid/ready handshake and sends an idle-high frame:
//             start bit (0), LSB-first data, optional even parity, stop (1).
//             Each bit is held for CLKS_PER_BIT clocks.
//  Options  : define SERIAL_TX_PARITY_EN to insert the even-parity bit.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             tx_line
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  // A one-bit word still needs a (constant zero) bit counter
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [BIT_W-1:0]  bit_q;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  shift_d;
  logic              line_q;
  logic              busy_q;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q;
`endif

  logic              baud_end;
  logic              accept;

  // Bit-boundary detection, baud wrap and next shift value
  assign baud_end = (baud_q == C_BAUD_LAST);
  assign baud_d   = baud_end ? '0 : baud_q + 1'b1;
  assign shift_d  = shift_q >> 1;

  assign tx_ready = (state_q == S_IDLE);
  assign accept   = tx_valid && tx_ready;

  assign tx_busy  = busy_q;
  assign tx_line  = line_q;

  // Frame sequencer; line and busy are registered alongside the state so
  // they change only on clock edges (or asynchronously on reset).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q  <= S_START;
            shift_q  <= tx_data;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^tx_data;
`endif
            baud_q   <= '0;
            line_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        S_START: begin
          baud_q <= baud_d;
          if (baud_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            line_q  <= shift_q[0];
          end
        end

        S_DATA: begin
          baud_q <= baud_d;
          if (baud_end) begin
            shift_q <= shift_d;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == C_BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= S_PARITY;
              line_q  <= parity_q;
`else
              state_q <= S_STOP;
              line_q  <= 1'b1;
`endif
            end else begin
              // Next data bit is the post-shift LSB
              line_q <= shift_d[0];
            end
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          baud_q <= baud_d;
          if (baud_end) begin
            state_q <= S_STOP;
            line_q  <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          baud_q <= baud_d;
          line_q <= 1'b1;
          if (baud_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          line_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
